aud_i2s_tx: RTL and testbench



---
 rtl/aud_pkg.sv | 18 +
 rtl/aud_sync_edge.sv | 32 +++
 rtl/aud_i2s_tx.sv | 131 +++++++++++++
 tb/tb_aud_i2s_tx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/aud_pkg.sv
// Shared definitions for the I2S audio transmitter: state encoding and defaults.
package aud_pkg;

  localparam int DATA_W_DEF = 16;

  // LRCK level that selects the left channel slot.
  localparam logic LEFT_CH = 1'b0;

  typedef enum logic [2:0] {
    S_IDLE,
    S_WAIT,
    S_LEFT,
    S_GAP_L,
    S_RIGHT,
    S_GAP_R
  } state_e;

endpackage

// File: rtl/aud_sync_edge.sv
// Multi-flop synchronizer for a codec clock pin, plus edge detection in the
// system clock domain. The synced level, a rise strobe and a fall strobe are provided.
module aud_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;

  // Shift the pin through the synchronizer chain and keep the last synced value for edge compare.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign o_level = sync_q[SYNC_STAGES-1];
  assign o_rise  = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign o_fall  = ~sync_q[SYNC_STAGES-1] & prev_q;

endmodule

// File: rtl/aud_i2s_tx.sv
// I2S transmitter toward the WM8731 DAC. The codec masters BCLK and DACLRCK;
// both are synchronized into i_clk, and the sample is shifted out MSB-first on
// BCLK falling edges with the standard one-BCLK I2S delay after each LRCK edge.
module aud_i2s_tx
  import aud_pkg::*;
#(
  parameter int DATA_W      = DATA_W_DEF,
  parameter int SYNC_STAGES = 2,
  parameter int DUP_RIGHT   = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_en,
  input  logic              i_bclk,
  input  logic              i_daclrck,
  input  logic [DATA_W-1:0] i_dac_data,
  output logic              o_aud_dacdat,
  output logic              o_sample_req,
  output logic              o_busy,
  output logic              o_frame_err
);

  localparam int                 CNT_W    = $clog2(DATA_W + 1);
  localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(DATA_W);

  logic bclkLevel, bclkRise, bclkFall;
  logic lrckLevel, lrckRise, lrckFall;

  aud_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_bclk (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_bclk),
    .o_level (bclkLevel),
    .o_rise  (bclkRise),
    .o_fall  (bclkFall)
  );

  aud_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_lrck (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_daclrck),
    .o_level (lrckLevel),
    .o_rise  (lrckRise),
    .o_fall  (lrckFall)
  );

  // Each strobe is tied to the synced level it was decoded from. A BCLK fall
  // that lands in the same cycle as any LRCK edge is swallowed: the LRCK edge
  // owns that cycle, which is exactly what produces the one-BCLK I2S delay.
  logic frameStart, rightStart, bitStrobe;
  assign frameStart = lrckFall && (lrckLevel == LEFT_CH);
  assign rightStart = lrckRise && (lrckLevel != LEFT_CH);
  assign bitStrobe  = bclkFall && !bclkRise && !bclkLevel && !lrckFall && !lrckRise;

  state_e            state_q;
  logic [DATA_W-1:0] shift_q;
  logic [DATA_W-1:0] sampleHold_q;
  logic [CNT_W-1:0]  bitCnt_q;
  logic              dacDat_q;
  logic              sampleReq_q;
  logic              busy_q;
  logic              frameErr_q;

  // Frame sequencer: LRCK edges restart slots, BCLK falls shift one bit out.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q      <= S_IDLE;
      shift_q      <= '0;
      sampleHold_q <= '0;
      bitCnt_q     <= '0;
      dacDat_q     <= 1'b0;
      sampleReq_q  <= 1'b0;
      busy_q       <= 1'b0;
      frameErr_q   <= 1'b0;
    end else begin
      sampleReq_q <= 1'b0;
      if (!i_en) begin
        state_q  <= S_IDLE;
        dacDat_q <= 1'b0;
        bitCnt_q <= '0;
        busy_q   <= 1'b0;
      end else if (frameStart && (state_q inside {S_WAIT, S_LEFT, S_RIGHT, S_GAP_R})) begin
        if (state_q == S_LEFT || state_q == S_RIGHT) begin
          frameErr_q <= 1'b1;
        end
        shift_q      <= i_dac_data;
        sampleHold_q <= i_dac_data;
        sampleReq_q  <= 1'b1;
        bitCnt_q     <= '0;
        dacDat_q     <= 1'b0;
        busy_q       <= 1'b1;
        state_q      <= S_LEFT;
      end else if (rightStart && (state_q inside {S_LEFT, S_GAP_L})) begin
        if (state_q == S_LEFT) begin
          frameErr_q <= 1'b1;
        end
        shift_q  <= (DUP_RIGHT != 0) ? sampleHold_q : '0;
        bitCnt_q <= '0;
        dacDat_q <= 1'b0;
        state_q  <= S_RIGHT;
      end else begin
        case (state_q)
          S_IDLE: begin
            dacDat_q <= 1'b0;
            state_q  <= S_WAIT;
          end
          S_LEFT, S_RIGHT: begin
            if (bitStrobe) begin
              if (bitCnt_q < CNT_LAST) begin
                dacDat_q <= shift_q[DATA_W-1];
                shift_q  <= {shift_q[DATA_W-2:0], 1'b0};
                bitCnt_q <= bitCnt_q + CNT_W'(1);
              end else begin
                dacDat_q <= 1'b0;
                state_q  <= (state_q == S_LEFT) ? S_GAP_L : S_GAP_R;
              end
            end
          end
          default: begin
          end
        endcase
      end
    end
  end

  assign o_aud_dacdat = dacDat_q;
  assign o_sample_req = sampleReq_q;
  assign o_busy       = busy_q;
  assign o_frame_err  = frameErr_q;

endmodule

// File: tb/tb_aud_i2s_tx.sv
// Testbench for aud_i2s_tx: plays the codec (BCLK = i_clk/8, 32 BCLK per slot),
// queues the expected DACDAT bit for every BCLK rise, and a monitor pops and
// compares on each rise. Two instances cover both right-channel modes.
module tb_aud_i2s_tx;

  typedef struct packed {
    logic d1;
    logic d0;
  } expBit_t;

  logic        i_clk = 1'b0;
  logic        i_rst;
  logic        i_en;
  logic        i_bclk;
  logic        i_daclrck;
  logic [15:0] i_dac_data;

  logic dacD1, reqD1, busyD1, errD1;
  logic dacD0, reqD0, busyD0, errD0;

  int errors   = 0;
  int checks   = 0;
  int expReq   = 0;
  int reqCount = 0;
  expBit_t expQ[$];

  always #5 i_clk = ~i_clk;

  aud_i2s_tx #(.DATA_W(16), .SYNC_STAGES(2), .DUP_RIGHT(1)) dut (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_bclk       (i_bclk),
    .i_daclrck    (i_daclrck),
    .i_dac_data   (i_dac_data),
    .o_aud_dacdat (dacD1),
    .o_sample_req (reqD1),
    .o_busy       (busyD1),
    .o_frame_err  (errD1)
  );

  aud_i2s_tx #(.DATA_W(16), .SYNC_STAGES(2), .DUP_RIGHT(0)) dutZ (
    .i_clk        (i_clk),
    .i_rst        (i_rst),
    .i_en         (i_en),
    .i_bclk       (i_bclk),
    .i_daclrck    (i_daclrck),
    .i_dac_data   (i_dac_data),
    .o_aud_dacdat (dacD0),
    .o_sample_req (reqD0),
    .o_busy       (busyD0),
    .o_frame_err  (errD0)
  );

  // Single comparison point: counts every check and reports mismatches.
  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h expected=%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // One BCLK period: falling edge (LRCK updated with it), 4 clocks low, 4 clocks high.
  task automatic bclkPeriod(input logic lr);
    @(negedge i_clk);
    i_bclk    = 1'b0;
    i_daclrck = lr;
    repeat (4) @(negedge i_clk);
    i_bclk = 1'b1;
    repeat (3) @(negedge i_clk);
  endtask

  // One LRCK frame. Expected bits are queued first; enAt/disAt toggle i_en
  // at the start of that left-slot BCLK period (-1 = never).
  task automatic applyStimulus(input logic [15:0] sample, input int leftPer, input int rightPer,
                               input bit active, input int enAt, input int disAt);
    expBit_t e;
    logic    d;
    bit      live;
    i_dac_data = sample;
    for (int p = 0; p < leftPer; p++) begin
      live = active && (disAt < 0 || p < disAt);
      d    = (live && p >= 1 && p <= 16) ? sample[16-p] : 1'b0;
      e.d1 = d;
      e.d0 = d;
      expQ.push_back(e);
    end
    for (int p = 0; p < rightPer; p++) begin
      live = active && (disAt < 0);
      d    = (live && p >= 1 && p <= 16) ? sample[16-p] : 1'b0;
      e.d1 = d;
      e.d0 = 1'b0;
      expQ.push_back(e);
    end
    if (active) expReq++;
    for (int p = 0; p < leftPer; p++) begin
      if (p == enAt) i_en = 1'b1;
      if (p == disAt) begin
        i_en = 1'b0;
        @(posedge i_clk);
        #1;
        checkOutput("stop_dacdat", 32'(dacD1), 32'(0));
        checkOutput("stop_busy", 32'(busyD1), 32'(0));
      end
      bclkPeriod(1'b0);
    end
    for (int p = 0; p < rightPer; p++) begin
      bclkPeriod(1'b1);
    end
    checkOutput("sample_req_count", 32'(reqCount), 32'(expReq));
    checkOutput("busy_frame_end", 32'(busyD1), 32'(active && disAt < 0));
  endtask

  // Codec-side monitor: the DAC samples DACDAT on every BCLK rise.
  initial begin
    expBit_t e;
    forever begin
      @(posedge i_bclk);
      if (expQ.size() == 0) begin
        checks++;
        errors++;
        $display("[TB] FAIL bit_queue: actual=empty expected=entry at %0t", $time);
      end else begin
        e = expQ.pop_front();
        checkOutput("dacdat_dup1", 32'(dacD1), 32'(e.d1));
        checkOutput("dacdat_dup0", 32'(dacD0), 32'(e.d0));
      end
    end
  end

  // Sample-request monitor: counts pulses and checks each is one cycle wide.
  initial begin
    logic reqPrev;
    reqPrev = 1'b0;
    forever begin
      @(negedge i_clk);
      if (reqPrev === 1'b1) checkOutput("sample_req_width", 32'(reqD1), 32'(0));
      if (reqD1 === 1'b1) reqCount++;
      reqPrev = reqD1;
    end
  end

  initial begin
    i_rst      = 1'b1;
    i_en       = 1'b0;
    i_bclk     = 1'b0;
    i_daclrck  = 1'b0;
    i_dac_data = 16'h0000;
    repeat (3) @(negedge i_clk);
    checkOutput("reset_dacdat", 32'(dacD1), 32'(0));
    checkOutput("reset_sample_req", 32'(reqD1), 32'(0));
    checkOutput("reset_busy", 32'(busyD1), 32'(0));
    checkOutput("reset_frame_err", 32'(errD1), 32'(0));
    i_rst = 1'b0;

    $display("[TB] enable asserted mid left slot");
    applyStimulus(16'h0000, 32, 32, 1'b0, 10, -1);

    $display("[TB] normal frames A5C3");
    applyStimulus(16'hA5C3, 32, 32, 1'b1, -1, -1);
    applyStimulus(16'hA5C3, 32, 32, 1'b1, -1, -1);
    checkOutput("frame_err_clean", 32'(errD1), 32'(0));

    $display("[TB] short frame after 8 left bits");
    applyStimulus(16'h1234, 9, 1, 1'b1, -1, -1);
    checkOutput("frame_err_set", 32'(errD1), 32'(1));

    applyStimulus(16'h7FFF, 32, 32, 1'b1, -1, -1);
    checkOutput("frame_err_sticky_dup1", 32'(errD1), 32'(1));
    checkOutput("frame_err_sticky_dup0", 32'(errD0), 32'(1));

    $display("[TB] sample sequence 8000, 0001");
    applyStimulus(16'h8000, 32, 32, 1'b1, -1, -1);
    applyStimulus(16'h0001, 32, 32, 1'b1, -1, -1);

    $display("[TB] stop at bit 5");
    applyStimulus(16'h5A5A, 32, 32, 1'b1, -1, 6);
    checkOutput("frame_err_after_stop", 32'(errD1), 32'(1));

    @(negedge i_clk);
    i_rst = 1'b1;
    @(negedge i_clk);
    checkOutput("rst_dacdat", 32'(dacD1), 32'(0));
    checkOutput("rst_sample_req", 32'(reqD1), 32'(0));
    checkOutput("rst_busy", 32'(busyD1), 32'(0));
    checkOutput("rst_frame_err_dup1", 32'(errD1), 32'(0));
    checkOutput("rst_frame_err_dup0", 32'(errD0), 32'(0));
    i_rst = 1'b0;

    $display("[TB] resync after reset");
    applyStimulus(16'h0000, 32, 32, 1'b0, 3, -1);
    applyStimulus(16'hC3A5, 32, 32, 1'b1, -1, -1);
    checkOutput("frame_err_after_resync", 32'(errD1), 32'(0));
    checkOutput("bit_queue_drained", 32'(expQ.size()), 32'(0));

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
